bicubic_engine: RTL and testbench
=================================

# bicubic_engine

Parametrised, stream-handshaked 4x4 bicubic interpolation engine. It is the successor to the fixed 8-bit single-channel bicubic core and sits between the line buffer, which supplies one 4-row column per beat, and the output pixel stream. It is generic in pixel width, coefficient format and channel count. It adds valid/ready backpressure, line-start window refill, coefficient pipelining and full-precision vertical accumulation.

## Interface
- DATA_WIDTH, 8, bits per channel sample (unsigned)
- CHANNELS, 3, channels per pixel; all channels share one set of weights
- COEF_W, 9, signed coefficient width
- COEF_FRAC, 7, coefficient fractional bits (1.0 = 2^COEF_FRAC)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  input column valid
- s_ready  out  1  engine accepts a column this cycle
- s_sol  in  1  start of line; qualified by s_valid & s_ready
- s_col  in  4*CHANNELS*DATA_WIDTH  column; row r, channel c at [(r*CHANNELS+c)*DATA_WIDTH +: DATA_WIDTH]; row0 at top
- s_hw  in  4*COEF_W  horizontal weights; w0 at [0 +: COEF_W]
- s_vw  in  4*COEF_W  vertical weights, same packing
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts
- m_pixel  out  CHANNELS*DATA_WIDTH  interpolated pixel; channel c at [c*DATA_WIDTH +: DATA_WIDTH]

## Operation
- Accept when s_valid & s_ready. The 4-column window shifts by one, and the newest column enters c0. c3 is the oldest column and takes weight w0. c0 takes w3. Row0 takes v w0, and row3 takes v w3.
- Fill counter: 0..4, saturating. Each accept increments it. An accept with s_sol loads 1, the new column becomes c0, and older columns are excluded from all outputs.
- An accept that leaves fill = 4 launches a window into the pipeline with the s_hw/s_vw sampled on that same beat. No other accept launches anything.
- Stage 1: per row and channel, H = sum(p_k * hw_k). p is zero-extended to signed. H is DATA_WIDTH+COEF_W+3 bits, exact.
- Stage 2: per channel, V = sum(H_r * vw_r). V is DATA_WIDTH+2*COEF_W+5 bits, exact. There is no intermediate truncation. vw is carried in a pipeline register alongside H.
- Stage 3: normalise by an arithmetic right shift of 2*COEF_FRAC, with rounding per Configuration. Then clip to [0, 2^DATA_WIDTH-1] and register into m_pixel.
- Weights whose sum is not 1.0 are computed exactly and then clipped. No error is flagged.
- Reset: m_valid=0, m_pixel=0, s_ready=1 after reset. The window, fill counter and all stage valids are cleared. Anything in flight mid-reset is discarded with no partial output.

## Timing
- Global enable en = !m_valid | m_ready. s_ready = en, and all stages advance only on en.
- Latency: a launching accept at cycle N gives m_valid=1 at N+3 when there is no stall. Throughput is one pixel per cycle.
- Stall: with m_valid & !m_ready, m_pixel is held stable and s_ready=0. Every stage holds its value, and no beat is lost or duplicated.
- m_pixel changes only when m_valid is 0 or on an accepted output.
- s_sol without s_valid has no effect. s_sol during a stall is not accepted.

## Configuration
- BICUBIC_ROUND_EN defined: add 2^(2*COEF_FRAC-1) before the normalise shift, giving round-half-up.
- BICUBIC_ROUND_EN undefined: pure arithmetic shift, which floors toward -inf.
- Clipping is applied in both cases.

## Structure
- bicubic_pkg: TAPS=4, default COEF_W/COEF_FRAC, and width functions for H and V. It also holds the rounding constant function.
- Sub-module bicubic_dot4: a 4-tap signed dot product, parametrised in operand widths and combinational.
  - 4*CHANNELS instances are used for the horizontal stage.
  - CHANNELS instances are used for the vertical stage.
- The top holds the window, fill counter, handshake, pipeline registers and clip.

## Test plan
Defaults are used unless stated. One-hot 128 is 1.0.
- Identity: hw = vw = {0,128,0,0}. Row1 ch0 columns 10,20,30,40 with s_sol on the first. Expect exactly one m_valid, at accept+3, with ch0 = 20.
- Clip: all samples 255, hw = {-16,144,144,-16}, vw = same. Expect 255. Then p = {0,255,0,0}, hw = {0,-128,0,0}. Expect 0.
- Rounding: all samples 3, hw = vw = {64,0,0,0}, giving V = 12288. Expect 1 with BICUBIC_ROUND_EN and 0 without.
- Backpressure: s_valid held high, m_ready low for 5 cycles mid-line. Expect s_ready=0 and m_pixel constant throughout, and an output sequence identical to the no-stall reference.
- Line start: 6 columns, then s_sol. Expect no m_valid for the first 3 accepts of the new line. The 4th accept outputs new-line data only.
- Reset mid-stream: rst for 1 cycle with 2 windows in flight. Expect m_valid=0 the next cycle, no stale outputs, and a fresh refill of 4 columns required.

Source files
------------

// File: rtl/bicubic_pkg.sv
// Shared constants and width helpers for the bicubic engine.
// Rounding of the final normalise step is selected by the BICUBIC_ROUND_EN macro.
package bicubic_pkg;

    localparam int TAPS          = 4;
    localparam int COEF_W_DEF    = 9;
    localparam int COEF_FRAC_DEF = 7;

    // Exact width of a horizontal 4-tap sum of zero-extended samples and signed weights.
    function automatic int h_width(input int data_w, input int coef_w);
        return data_w + coef_w + 3;
    endfunction

    // Exact width of the vertical 4-tap sum over horizontal results.
    function automatic int v_width(input int data_w, input int coef_w);
        return data_w + 2 * coef_w + 5;
    endfunction

    // Half an LSB of the normalised result, added before the shift for round-half-up.
    function automatic int round_const(input int coef_frac);
        return 1 << (2 * coef_frac - 1);
    endfunction

endpackage

// File: rtl/bicubic_dot4.sv
// Combinational exact 4-tap signed dot product: y = sum(a_k * b_k).
// Operands are treated as signed two's complement of widths A_W and B_W.
module bicubic_dot4
    import bicubic_pkg::*;
#(
    parameter int A_W = 9,
    parameter int B_W = 9,
    parameter int O_W = 20
) (
    input  logic [TAPS*A_W-1:0] a,
    input  logic [TAPS*B_W-1:0] b,
    output logic [O_W-1:0]      y
);

    logic signed [O_W-1:0] a_ext [TAPS];
    logic signed [O_W-1:0] b_ext [TAPS];
    logic signed [O_W-1:0] acc_s;

    // Widen every operand to the result width so products and the sum wrap nowhere.
    always_comb begin
        acc_s = '0;
        for (int k = 0; k < TAPS; k++) begin
            a_ext[k] = {{(O_W-A_W){a[k*A_W+A_W-1]}}, a[k*A_W +: A_W]};
            b_ext[k] = {{(O_W-B_W){b[k*B_W+B_W-1]}}, b[k*B_W +: B_W]};
            acc_s    = acc_s + a_ext[k] * b_ext[k];
        end
        y = acc_s;
    end

endmodule

// File: rtl/bicubic_engine.sv
// Stream-handshaked 4x4 bicubic interpolation engine: column window, exact H/V dot products, normalise and clip.
// Define BICUBIC_ROUND_EN for round-half-up normalisation; otherwise the shift floors toward -inf.
module bicubic_engine
    import bicubic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int COEF_W     = COEF_W_DEF,
    parameter int COEF_FRAC  = COEF_FRAC_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic                               s_sol,
    input  logic [TAPS*CHANNELS*DATA_WIDTH-1:0] s_col,
    input  logic [TAPS*COEF_W-1:0]             s_hw,
    input  logic [TAPS*COEF_W-1:0]             s_vw,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0]     m_pixel
);

    localparam int HW    = h_width(DATA_WIDTH, COEF_W);
    localparam int VW    = v_width(DATA_WIDTH, COEF_W);
    localparam int COL_W = TAPS * CHANNELS * DATA_WIDTH;
    localparam int PIX_W = CHANNELS * DATA_WIDTH;
    localparam int SHIFT = 2 * COEF_FRAC;
    localparam int NH    = TAPS * CHANNELS;
    localparam logic signed [VW-1:0] PIX_MAX = VW'((1 << DATA_WIDTH) - 1);

    logic                en_s;
    logic                accept_s;
    logic                launch_s;

    logic [COL_W-1:0]    win_q [TAPS];
    logic [COL_W-1:0]    win_d [TAPS];
    logic [2:0]          fill_q, fill_d;

    logic                s1_valid_q, s1_valid_d;
    logic [NH*HW-1:0]    h_q, h_d;
    logic [TAPS*COEF_W-1:0] vw_q, vw_d;
    logic                s2_valid_q, s2_valid_d;
    logic [CHANNELS*VW-1:0] v_q, v_d;
    logic                m_valid_q, m_valid_d;
    logic [PIX_W-1:0]    m_pixel_q, m_pixel_d;

    logic [TAPS*(DATA_WIDTH+1)-1:0] h_a [NH];
    logic [TAPS*HW-1:0]             v_a [CHANNELS];
    logic [NH*HW-1:0]               h_sum;
    logic [CHANNELS*VW-1:0]         v_sum;
    logic [PIX_W-1:0]               pix_s;
    logic signed [VW-1:0]           v_ch;
    logic signed [VW-1:0]           v_norm;

    // Window shift and fill tracking; a start-of-line beat restarts the fill so older columns age out unused.
    always_comb begin
        en_s     = !m_valid_q || m_ready;
        accept_s = s_valid && en_s;
        win_d    = win_q;
        fill_d   = fill_q;
        if (accept_s) begin
            win_d[0] = s_col;
            for (int k = 1; k < TAPS; k++) begin
                win_d[k] = win_q[k-1];
            end
            if (s_sol) begin
                fill_d = 3'd1;
            end else if (fill_q == 3'd4) begin
                fill_d = 3'd4;
            end else begin
                fill_d = fill_q + 3'd1;
            end
        end else begin
            fill_d = fill_q;
        end
        launch_s = accept_s && (fill_d == 3'd4);
    end

    // Operand routing: c3 (oldest) meets w0, and each channel gathers its four row sums for the vertical pass.
    always_comb begin
        for (int g = 0; g < NH; g++) begin
            for (int k = 0; k < TAPS; k++) begin
                h_a[g][k*(DATA_WIDTH+1) +: DATA_WIDTH+1] =
                    {1'b0, win_d[TAPS-1-k][g*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            for (int r = 0; r < TAPS; r++) begin
                v_a[c][r*HW +: HW] = h_q[(r*CHANNELS+c)*HW +: HW];
            end
        end
    end

    for (genvar g = 0; g < NH; g++) begin : g_hdot
        bicubic_dot4 #(
            .A_W (DATA_WIDTH + 1),
            .B_W (COEF_W),
            .O_W (HW)
        ) u_hdot (
            .a (h_a[g]),
            .b (s_hw),
            .y (h_sum[g*HW +: HW])
        );
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_vdot
        bicubic_dot4 #(
            .A_W (HW),
            .B_W (COEF_W),
            .O_W (VW)
        ) u_vdot (
            .a (v_a[c]),
            .b (vw_q),
            .y (v_sum[c*VW +: VW])
        );
    end

    // Normalise each channel, then clip to the unsigned sample range.
    always_comb begin
        pix_s  = '0;
        v_ch   = '0;
        v_norm = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            v_ch = v_q[c*VW +: VW];
`ifdef BICUBIC_ROUND_EN
            v_ch = v_ch + VW'(round_const(COEF_FRAC));
`endif
            v_norm = v_ch >>> SHIFT;
            if (v_norm[VW-1]) begin
                pix_s[c*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if (v_norm > PIX_MAX) begin
                pix_s[c*DATA_WIDTH +: DATA_WIDTH] = '1;
            end else begin
                pix_s[c*DATA_WIDTH +: DATA_WIDTH] = v_norm[DATA_WIDTH-1:0];
            end
        end
    end

    // Pipeline advance: every stage moves together on en, and holds otherwise.
    always_comb begin
        s1_valid_d = s1_valid_q;
        h_d        = h_q;
        vw_d       = vw_q;
        s2_valid_d = s2_valid_q;
        v_d        = v_q;
        m_valid_d  = m_valid_q;
        m_pixel_d  = m_pixel_q;
        if (en_s) begin
            s1_valid_d = launch_s;
            h_d        = h_sum;
            vw_d       = s_vw;
            s2_valid_d = s1_valid_q;
            v_d        = v_sum;
            m_valid_d  = s2_valid_q;
            if (s2_valid_q) begin
                m_pixel_d = pix_s;
            end else begin
                m_pixel_d = m_pixel_q;
            end
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // State registers with synchronous reset; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                win_q[k] <= '0;
            end
            fill_q     <= 3'd0;
            s1_valid_q <= 1'b0;
            h_q        <= '0;
            vw_q       <= '0;
            s2_valid_q <= 1'b0;
            v_q        <= '0;
            m_valid_q  <= 1'b0;
            m_pixel_q  <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                win_q[k] <= win_d[k];
            end
            fill_q     <= fill_d;
            s1_valid_q <= s1_valid_d;
            h_q        <= h_d;
            vw_q       <= vw_d;
            s2_valid_q <= s2_valid_d;
            v_q        <= v_d;
            m_valid_q  <= m_valid_d;
            m_pixel_q  <= m_pixel_d;
        end
    end

    assign s_ready = en_s;
    assign m_valid = m_valid_q;
    assign m_pixel = m_pixel_q;

endmodule

// File: tb/tb_bicubic_engine.sv
// Directed + randomized bench for bicubic_engine against a plain-arithmetic bicubic reference model.
module tb_bicubic_engine;

    localparam int DW    = 8;
    localparam int CH    = 3;
    localparam int CW    = 9;
    localparam int COL_W = 4 * CH * DW;
    localparam int PIX_W = CH * DW;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid, s_ready, s_sol;
    logic [COL_W-1:0] s_col;
    logic [4*CW-1:0]  s_hw, s_vw;
    logic             m_valid, m_ready;
    logic [PIX_W-1:0] m_pixel;

    int n_tests, n_fail;
    int cyc, n_out, n0;
    int last_out_cyc, last_acc_cyc;
    logic [PIX_W-1:0] last_px;

    // Reference model: window of samples [col][row][ch] (col 0 newest), fill, and a 3-deep latency line.
    int               mwin [4][4][CH];
    int               mfill;
    logic             pv  [3];
    logic [PIX_W-1:0] ppx [3];

    bicubic_engine #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .COEF_W     (CW),
        .COEF_FRAC  (7)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_sol   (s_sol),
        .s_col   (s_col),
        .s_hw    (s_hw),
        .s_vw    (s_vw),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_pixel (m_pixel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*CW-1:0] pack4(input int w0, input int w1, input int w2, input int w3);
        return {9'(w3), 9'(w2), 9'(w1), 9'(w0)};
    endfunction

    function automatic int coef(input logic [4*CW-1:0] w, input int i);
        logic signed [CW-1:0] t;
        t = w[i*CW +: CW];
        return int'(t);
    endfunction

    function automatic logic [COL_W-1:0] rand_col();
        logic [COL_W-1:0] r;
        for (int i = 0; i < COL_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [COL_W-1:0] const_col(input logic [7:0] b);
        logic [COL_W-1:0] r;
        for (int i = 0; i < 4 * CH; i++) r[i*DW +: DW] = b;
        return r;
    endfunction

    function automatic logic [4*CW-1:0] rand_w();
        return pack4(int'($urandom_range(200)) - 40, int'($urandom_range(200)) - 40,
                     int'($urandom_range(200)) - 40, int'($urandom_range(200)) - 40);
    endfunction

    task automatic model_reset();
        mfill = 0;
        for (int i = 0; i < 3; i++) begin
            pv[i]  = 1'b0;
            ppx[i] = '0;
        end
    endtask

    // Pixel = clip(normalise(sum over rows r and taps k of vw_r * hw_k * sample)), c3 pairs with w0.
    task automatic model_accept(input logic sol, input logic [COL_W-1:0] col,
                                input logic [4*CW-1:0] hw, input logic [4*CW-1:0] vw,
                                output logic launch, output logic [PIX_W-1:0] px);
        longint acc;
        for (int k = 3; k >= 1; k--)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < CH; c++) mwin[k][r][c] = mwin[k-1][r][c];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < CH; c++) mwin[0][r][c] = int'(col[(r*CH+c)*DW +: DW]);
        mfill  = sol ? 1 : (mfill < 4 ? mfill + 1 : 4);
        launch = (mfill == 4);
        px     = '0;
        for (int c = 0; c < CH; c++) begin
            acc = 0;
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++)
                    acc += longint'(coef(vw, r)) * coef(hw, k) * mwin[3-k][r][c];
`ifdef BICUBIC_ROUND_EN
            acc += 64'sd8192;
`endif
            acc = acc >>> 14;
            if (acc < 0) px[c*DW +: DW] = 8'd0;
            else if (acc > 255) px[c*DW +: DW] = 8'd255;
            else px[c*DW +: DW] = 8'(acc);
        end
    endtask

    // One clock: drive inputs at the falling edge, check outputs against the model, then advance the model.
    task automatic step(input logic v, input logic sol, input logic [COL_W-1:0] col,
                        input logic [4*CW-1:0] hw, input logic [4*CW-1:0] vw,
                        input logic mr, input logic r);
        logic en, acc, launch;
        logic [PIX_W-1:0] px;
        @(negedge clk);
        s_valid = v; s_sol = sol; s_col = col; s_hw = hw; s_vw = vw; m_ready = mr; rst = r;
        #1;
        if (r) begin
            model_reset();
        end else begin
            en = !pv[2] || mr;
            check("s_ready", 96'(s_ready), 96'(en));
            check("m_valid", 96'(m_valid), 96'(pv[2]));
            if (pv[2]) check("m_pixel", 96'(m_pixel), 96'(ppx[2]));
            if (pv[2] && mr) begin
                n_out++;
                last_px      = m_pixel;
                last_out_cyc = cyc;
            end
            acc    = v && en;
            launch = 1'b0;
            px     = '0;
            if (acc) begin
                last_acc_cyc = cyc;
                model_accept(sol, col, hw, vw, launch, px);
            end
            if (en) begin
                pv[2] = pv[1]; ppx[2] = pv[1] ? ppx[1] : ppx[2];
                pv[1] = pv[0]; ppx[1] = ppx[0];
                pv[0] = acc && launch; ppx[0] = px;
            end
        end
        cyc++;
    endtask

    initial begin
        logic [4*CW-1:0]  hw, vw;
        logic [COL_W-1:0] col;
        logic [PIX_W-1:0] held;
        logic [7:0]       rnd_exp;

        n_tests = 0; n_fail = 0; cyc = 0; n_out = 0;
        last_out_cyc = 0; last_acc_cyc = 0; last_px = '0;
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < CH; c++) mwin[k][r][c] = 0;
        model_reset();
        s_valid = 1'b0; s_sol = 1'b0; s_col = '0; s_hw = '0; s_vw = '0; m_ready = 1'b1; rst = 1'b1;

        // Reset state
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        check("rst_pixel", 96'(m_pixel), 96'(0));
        check("rst_ready", 96'(s_ready), 96'(1));

        // Identity: row1 ch0 columns 10,20,30,40 -> 20
        hw = pack4(0, 128, 0, 0);
        n0 = n_out;
        for (int i = 0; i < 4; i++) begin
            col = rand_col();
            col[24 +: 8] = 8'(10 * (i + 1));
            step(1'b1, i == 0, col, hw, hw, 1'b1, 1'b0);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, rand_col(), hw, hw, 1'b1, 1'b0);
        check("id_count", 96'(n_out - n0), 96'(1));
        check("id_latency", 96'(last_out_cyc - last_acc_cyc), 96'(3));
        check("id_pixel", 96'(last_px[7:0]), 96'(20));

        // Clip high then clip low
        hw = pack4(-16, 144, 144, -16);
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, const_col(8'hff), hw, hw, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, hw, hw, 1'b1, 1'b0);
        check("clip_hi", 96'(last_px), 96'({3{8'hff}}));
        vw = hw;
        hw = pack4(0, -128, 0, 0);
        for (int i = 0; i < 4; i++)
            step(1'b1, i == 0, const_col((i == 1) ? 8'hff : 8'h00), hw, vw, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, hw, vw, 1'b1, 1'b0);
        check("clip_lo", 96'(last_px), 96'(0));

        // Rounding: V = 12288
        hw = pack4(64, 0, 0, 0);
`ifdef BICUBIC_ROUND_EN
        rnd_exp = 8'd1;
`else
        rnd_exp = 8'd0;
`endif
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, const_col(8'd3), hw, hw, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, hw, hw, 1'b1, 1'b0);
        check("round", 96'(last_px), 96'({3{rnd_exp}}));

        // Backpressure mid-line
        hw = rand_w(); vw = rand_w();
        held = '0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i == 0, rand_col(), hw, vw, !(i >= 8 && i < 13), 1'b0);
            if (i == 8) held = ppx[2];
            if (i > 8 && i < 13) begin
                check("stall_hold", 96'(m_pixel), 96'(held));
                check("stall_ready", 96'(s_ready), 96'(0));
            end
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, hw, vw, 1'b1, 1'b0);

        // Line start after 6 columns
        for (int i = 0; i < 6; i++) step(1'b1, i == 0, rand_col(), rand_w(), rand_w(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, hw, vw, 1'b1, 1'b0);
        n0 = n_out;
        for (int i = 0; i < 3; i++) step(1'b1, i == 0, rand_col(), rand_w(), rand_w(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, hw, vw, 1'b1, 1'b0);
        check("sol_no_out", 96'(n_out - n0), 96'(0));
        step(1'b1, 1'b0, rand_col(), rand_w(), rand_w(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, hw, vw, 1'b1, 1'b0);
        check("sol_one_out", 96'(n_out - n0), 96'(1));

        // Reset with windows in flight
        for (int i = 0; i < 6; i++) step(1'b1, i == 0, rand_col(), rand_w(), rand_w(), 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, hw, vw, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, hw, vw, 1'b1, 1'b0);
        check("rst_mid_valid", 96'(m_valid), 96'(0));
        n0 = n_out;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_col(), rand_w(), rand_w(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, hw, vw, 1'b1, 1'b0);
        check("rst_refill_none", 96'(n_out - n0), 96'(0));
        step(1'b1, 1'b0, rand_col(), rand_w(), rand_w(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, hw, vw, 1'b1, 1'b0);
        check("rst_refill_one", 96'(n_out - n0), 96'(1));

        // Randomized traffic with random backpressure and line starts
        for (int i = 0; i < 400; i++)
            step($urandom_range(9) < 7, $urandom_range(19) == 0, rand_col(), rand_w(), rand_w(),
                 $urandom_range(3) != 0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, hw, vw, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
